// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the NRZI receive path: FSM states, line-state encodings, thresholds.
// Latency: none (definitions only); backpressure: none.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    EOP  = 3'd3,
    ERR  = 3'd4
  } rxState_t;

  // Encoded directly as {dp, dm} so classification is a plain cast.
  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_K   = 2'b01,
    LINE_J   = 2'b10,
    LINE_SE1 = 2'b11
  } lineState_t;

  localparam logic [2:0] STUFF_LIMIT   = 3'd6;
  localparam logic [1:0] EOP_SE0_MIN   = 2'd2;
  localparam logic [2:0] SYNC_ZERO_MIN = 3'd5;

  function automatic logic isJk(input lineState_t ls);
    return (ls == LINE_J) || (ls == LINE_K);
  endfunction

endpackage

// File: rtl/nrzi_line_decoder.sv
// Line classifier plus NRZI decode; lineState/lineBit are combinational from dp/dm and the previous J/K sample.
// Latency: 0 cycles (previous-sample register updates on sampleEn J/K samples); backpressure: none.
module nrzi_line_decoder
  import usb_rx_pkg::*;
(
  input  logic       useClk,
  input  logic       rstN,
  input  logic       sampleEn,
  input  logic       dp,
  input  logic       dm,
  output lineState_t lineState,
  output logic       lineBit
);

  lineState_t prevJk;

  always_comb begin
    lineState = lineState_t'({dp, dm});
    lineBit   = (lineState == prevJk);
  end

  // SE0/SE1 carry no NRZI level, so they never disturb the reference.
  always_ff @(posedge useClk or negedge rstN) begin
    if (!rstN) begin
      prevJk <= LINE_J;
    end else if (sampleEn && isJk(lineState)) begin
      prevJk <= lineState;
    end
  end

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: SYNC detect, bit unstuffing, LSB-first byte assembly, EOP and error detection.
// Latency: pulses appear one useClk after the deciding sampleEn cycle; backpressure: none, sampleEn paces the line.
module nrzi_rx_decoder
  import usb_rx_pkg::*;
(
  input  logic       useClk,
  input  logic       rstN,
  input  logic       sampleEn,
  input  logic       dp,
  input  logic       dm,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       rxActive,
  output logic       rxEop,
  output logic       rxError
);

  lineState_t lineState;
  logic       lineBit;

  rxState_t   state, stateNxt;
  logic [2:0] zeroCnt, zeroNxt;
  logic [2:0] bitCnt, bitNxt;
  logic [2:0] onesCnt, onesNxt;
  logic [1:0] se0Cnt, se0Nxt;
  logic [7:0] shiftReg, shiftNxt;
  logic [7:0] dataNxt;
  logic       validNxt, activeNxt, eopNxt, errNxt;

  nrzi_line_decoder uLineDec (
    .useClk    (useClk),
    .rstN      (rstN),
    .sampleEn  (sampleEn),
    .dp        (dp),
    .dm        (dm),
    .lineState (lineState),
    .lineBit   (lineBit)
  );

  always_ff @(posedge useClk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      zeroCnt  <= 3'd0;
      bitCnt   <= 3'd0;
      onesCnt  <= 3'd0;
      se0Cnt   <= 2'd0;
      shiftReg <= 8'h00;
      rxData   <= 8'h00;
      rxValid  <= 1'b0;
      rxActive <= 1'b0;
      rxEop    <= 1'b0;
      rxError  <= 1'b0;
    end else begin
      state    <= stateNxt;
      zeroCnt  <= zeroNxt;
      bitCnt   <= bitNxt;
      onesCnt  <= onesNxt;
      se0Cnt   <= se0Nxt;
      shiftReg <= shiftNxt;
      rxData   <= dataNxt;
      rxValid  <= validNxt;
      rxActive <= activeNxt;
      rxEop    <= eopNxt;
      rxError  <= errNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    zeroNxt  = zeroCnt;
    bitNxt   = bitCnt;
    onesNxt  = onesCnt;
    se0Nxt   = se0Cnt;
    shiftNxt = shiftReg;
    dataNxt  = rxData;
    validNxt = 1'b0;
    eopNxt   = 1'b0;
    errNxt   = 1'b0;

    if (sampleEn) begin
      case (state)
        IDLE: begin
          if (lineState == LINE_K) begin
            stateNxt = SYNC;
            zeroNxt  = 3'd1;
          end
        end

        SYNC: begin
          if (!isJk(lineState)) begin
            stateNxt = IDLE;
          end else if (!lineBit) begin
            if (zeroCnt != 3'd7) zeroNxt = zeroCnt + 3'd1;
          end else if (zeroCnt >= SYNC_ZERO_MIN) begin
            // The closing 1 of SYNC counts toward the first stuffing run.
            stateNxt = DATA;
            bitNxt   = 3'd0;
            onesNxt  = 3'd1;
          end else begin
            stateNxt = IDLE;
          end
        end

        DATA: begin
          case (lineState)
            LINE_SE0: begin
              stateNxt = EOP;
              se0Nxt   = 2'd1;
            end
            LINE_SE1: begin
              stateNxt = ERR;
              errNxt   = 1'b1;
              se0Nxt   = 2'd0;
            end
            default: begin
              if (onesCnt == STUFF_LIMIT) begin
                if (lineBit) begin
                  stateNxt = ERR;
                  errNxt   = 1'b1;
                  se0Nxt   = 2'd0;
                end else begin
                  onesNxt = 3'd0;
                end
              end else begin
                shiftNxt = {lineBit, shiftReg[7:1]};
                bitNxt   = bitCnt + 3'd1;
                onesNxt  = lineBit ? onesCnt + 3'd1 : 3'd0;
                if (bitCnt == 3'd7) begin
                  dataNxt  = shiftNxt;
                  validNxt = 1'b1;
                end
              end
            end
          endcase
        end

        EOP: begin
          case (lineState)
            LINE_SE0: begin
              if (se0Cnt != 2'd3) se0Nxt = se0Cnt + 2'd1;
            end
            LINE_J: begin
              if (se0Cnt >= EOP_SE0_MIN) begin
                // A partial byte is dropped but still flagged alongside the EOP.
                stateNxt = IDLE;
                eopNxt   = 1'b1;
                errNxt   = (bitCnt != 3'd0);
              end else begin
                stateNxt = ERR;
                errNxt   = 1'b1;
                se0Nxt   = 2'd0;
              end
            end
            default: begin
              stateNxt = ERR;
              errNxt   = 1'b1;
              se0Nxt   = 2'd0;
            end
          endcase
        end

        ERR: begin
          // se0Cnt doubles as the "SE0 seen" flag while waiting to resync.
          case (lineState)
            LINE_SE0: se0Nxt = 2'd1;
            LINE_J: begin
              if (se0Cnt != 2'd0) begin
                stateNxt = IDLE;
                se0Nxt   = 2'd0;
              end
            end
            default: se0Nxt = 2'd0;
          endcase
        end

        default: stateNxt = IDLE;
      endcase
    end

    activeNxt = (stateNxt == DATA) || (stateNxt == EOP);
  end

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: table-driven packet vectors plus hand-written corner sequences.
// Latency: outputs sampled 1 time unit after each rising edge; backpressure: none.
module tb_nrzi_rx_decoder;

  logic       useClk = 1'b0;
  logic       rstN;
  logic       sampleEn;
  logic       dp;
  logic       dm;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxActive;
  logic       rxEop;
  logic       rxError;

  always #5 useClk = ~useClk;

  nrzi_rx_decoder dut (
    .useClk   (useClk),
    .rstN     (rstN),
    .sampleEn (sampleEn),
    .dp       (dp),
    .dm       (dm),
    .rxData   (rxData),
    .rxValid  (rxValid),
    .rxActive (rxActive),
    .rxEop    (rxEop),
    .rxError  (rxError)
  );

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] L0 = 2'b00;
  localparam logic [1:0] L1 = 2'b11;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam int NV = 23;

  typedef struct {
    logic [1:0] line;
    logic       vld;
    logic [7:0] dat;
    logic       act;
    logic       eop;
    logic       err;
  } vec_t;

  vec_t tbl[NV];

  int tests = 0;
  int fails = 0;
  logic [7:0] gotData[$];
  int eopSeen;
  int errSeen;
  int strayPulse = 0;
  logic lvl;   // current NRZI level, 1 = J

  function automatic vec_t mk(input logic [1:0] l, input logic v, input logic [7:0] d,
                              input logic a, input logic e, input logic r);
    vec_t t;
    t.line = l; t.vld = v; t.dat = d; t.act = a; t.eop = e; t.err = r;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample outputs just after the rising edge.
  task automatic cyc(input logic [1:0] ls, input logic en);
    @(negedge useClk);
    {dp, dm} = ls;
    sampleEn = en;
    @(posedge useClk);
    #1;
    if (rxValid) gotData.push_back(rxData);
    if (rxEop) eopSeen++;
    if (rxError) errSeen++;
    if ((rxValid || rxEop || rxError) && !en) strayPulse++;
  endtask

  task automatic sendBit(input logic b);
    if (!b) lvl = ~lvl;
    cyc(lvl ? LJ : LK, 1'b1);
  endtask

  task automatic sendSync();
    for (int i = 0; i < 3; i++) begin
      cyc(LK, 1'b1);
      cyc(LJ, 1'b1);
    end
    cyc(LK, 1'b1);
    cyc(LK, 1'b1);
    lvl = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) sendBit(v[i]);
  endtask

  task automatic sendEop();
    cyc(L0, 1'b1);
    cyc(L0, 1'b1);
    cyc(LJ, 1'b1);
    lvl = 1'b1;
  endtask

  task automatic clearLog();
    gotData.delete();
    eopSeen = 0;
    errSeen = 0;
  endtask

  task automatic doReset();
    @(negedge useClk);
    rstN = 1'b0;
    sampleEn = 1'b0;
    repeat (2) @(negedge useClk);
    rstN = 1'b1;
    lvl = 1'b1;
  endtask

  // gap > 0 inserts strobe-low cycles that drive the complementary line state.
  task automatic runTable(input int gap);
    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].line, 1'b1);
      check($sformatf("g%0d row%0d vld", gap, i), rxValid, tbl[i].vld);
      check($sformatf("g%0d row%0d dat", gap, i), rxData, tbl[i].dat);
      check($sformatf("g%0d row%0d act", gap, i), rxActive, tbl[i].act);
      check($sformatf("g%0d row%0d eop", gap, i), rxEop, tbl[i].eop);
      check($sformatf("g%0d row%0d err", gap, i), rxError, tbl[i].err);
      for (int g = 0; g < gap; g++) begin
        cyc(~tbl[i].line, 1'b0);
        check($sformatf("g%0d row%0d hold%0d pulses", gap, i, g),
              {rxValid, rxEop, rxError}, 3'b000);
        check($sformatf("g%0d row%0d hold%0d act", gap, i, g), rxActive, tbl[i].act);
        check($sformatf("g%0d row%0d hold%0d dat", gap, i, g), rxData, tbl[i].dat);
      end
    end
  endtask

  initial begin
    // Idle J with an SE1 glitch, SYNC KJKJKJKK, byte 0xD2 (LSB first), SE0 SE0 J.
    tbl[0]  = mk(LJ, N, 8'h00, N, N, N);
    tbl[1]  = mk(L1, N, 8'h00, N, N, N);
    tbl[2]  = mk(LJ, N, 8'h00, N, N, N);
    tbl[3]  = mk(LK, N, 8'h00, N, N, N);
    tbl[4]  = mk(LJ, N, 8'h00, N, N, N);
    tbl[5]  = mk(LK, N, 8'h00, N, N, N);
    tbl[6]  = mk(LJ, N, 8'h00, N, N, N);
    tbl[7]  = mk(LK, N, 8'h00, N, N, N);
    tbl[8]  = mk(LJ, N, 8'h00, N, N, N);
    tbl[9]  = mk(LK, N, 8'h00, N, N, N);
    tbl[10] = mk(LK, N, 8'h00, Y, N, N);
    tbl[11] = mk(LJ, N, 8'h00, Y, N, N);
    tbl[12] = mk(LJ, N, 8'h00, Y, N, N);
    tbl[13] = mk(LK, N, 8'h00, Y, N, N);
    tbl[14] = mk(LJ, N, 8'h00, Y, N, N);
    tbl[15] = mk(LJ, N, 8'h00, Y, N, N);
    tbl[16] = mk(LK, N, 8'h00, Y, N, N);
    tbl[17] = mk(LK, N, 8'h00, Y, N, N);
    tbl[18] = mk(LK, Y, 8'hD2, Y, N, N);
    tbl[19] = mk(L0, N, 8'hD2, Y, N, N);
    tbl[20] = mk(L0, N, 8'hD2, Y, N, N);
    tbl[21] = mk(LJ, N, 8'hD2, N, Y, N);
    tbl[22] = mk(LJ, N, 8'hD2, N, N, N);

    rstN = 1'b0;
    sampleEn = 1'b0;
    {dp, dm} = LJ;
    lvl = 1'b1;
    clearLog();
    #3;
    check("reset outputs", {rxData, rxValid, rxActive, rxEop, rxError}, 12'h000);
    repeat (2) @(negedge useClk);
    rstN = 1'b1;

    runTable(0);
    doReset();
    runTable(3);

    // 0xFF needs a stuffed 0 once six 1s have run (SYNC's closing 1 plus five data 1s).
    clearLog();
    cyc(LJ, 1'b1);
    sendSync();
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    sendByte(8'h01);
    sendEop();
    check("stuff byte count", gotData.size(), 2);
    check("stuff byte0", gotData.size() > 0 ? gotData[0] : 8'hxx, 8'hFF);
    check("stuff byte1", gotData.size() > 1 ? gotData[1] : 8'hxx, 8'h01);
    check("stuff errors", errSeen, 0);
    check("stuff eops", eopSeen, 1);

    // Reset asserted mid-byte: outputs clear at once, leftover bits are ignored.
    clearLog();
    cyc(LJ, 1'b1);
    sendSync();
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    check("midbyte active", rxActive, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    check("async reset outputs", {rxData, rxValid, rxActive, rxEop, rxError}, 12'h000);
    @(negedge useClk);
    sampleEn = 1'b0;
    @(negedge useClk);
    rstN = 1'b1;
    for (int i = 3; i < 8; i++) sendBit(tbl[0].dat[0] | (8'hD2 >> i) & 8'h01);
    sendEop();
    check("post-reset leftovers valid", gotData.size(), 0);
    check("post-reset leftovers pulses", eopSeen + errSeen, 0);
    cyc(LJ, 1'b1);
    sendSync();
    sendByte(8'hD2);
    sendEop();
    check("post-reset packet count", gotData.size(), 1);
    check("post-reset packet data", gotData.size() > 0 ? gotData[0] : 8'hxx, 8'hD2);
    check("post-reset packet eop", eopSeen, 1);
    check("post-reset packet err", errSeen, 0);

    // Partial byte at EOP: error and EOP together.
    clearLog();
    cyc(LJ, 1'b1);
    sendSync();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    cyc(L0, 1'b1);
    cyc(L0, 1'b1);
    cyc(LJ, 1'b1);
    lvl = 1'b1;
    check("partial eop+err", {rxEop, rxError}, 2'b11);
    check("partial no valid", gotData.size(), 0);

    // Seventh consecutive 1 (SYNC's closing 1 plus six data 1s) is a stuff error.
    clearLog();
    cyc(LJ, 1'b1);
    sendSync();
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    check("stuff run no err yet", {errSeen[0], rxActive}, 2'b01);
    sendBit(1'b1);
    check("stuff err pulse", rxError, 1'b1);
    check("stuff err inactive", rxActive, 1'b0);
    sendBit(1'b1);
    sendSync();
    sendByte(8'hD2);
    check("err state no valid", gotData.size(), 0);
    check("err state single pulse", errSeen, 1);
    check("err state inactive", rxActive, 1'b0);
    cyc(L0, 1'b1);
    cyc(LJ, 1'b1);
    lvl = 1'b1;
    cyc(LJ, 1'b1);
    sendSync();
    sendByte(8'hD2);
    sendEop();
    check("recovered count", gotData.size(), 1);
    check("recovered data", gotData.size() > 0 ? gotData[0] : 8'hxx, 8'hD2);
    check("recovered eop", eopSeen, 1);

    check("pulses only after strobe", strayPulse, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nrzi_rx_decoder.md
NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

Interface
REQ-001 SHALL have port: useClk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rstN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: sampleEn  input  1  bit strobe; line sampled and state advanced only in cycles where high.
REQ-004 SHALL have port: dp  input  1  line D+ (already synchronized).
REQ-005 SHALL have port: dm  input  1  line D- (already synchronized).
REQ-006 SHALL have port: rxData  output  8  last assembled byte, LSB received first.
REQ-007 SHALL have port: rxValid  output  1  one-cycle pulse, rxData valid.
REQ-008 SHALL have port: rxActive  output  1  high from SYNC completion until EOP or error.
REQ-009 SHALL have port: rxEop  output  1  one-cycle pulse on valid EOP.
REQ-010 SHALL have port: rxError  output  1  one-cycle pulse on stuff error, SE1 or partial byte at EOP.

Function
REQ-011 Line states SHALL be: J = (dp=1, dm=0); K = (0,1); SE0 = (0,0); SE1 = (1,1).
REQ-012 NRZI decode SHALL be: bit=1 if sampled J/K equals previous J/K sample, else 0; previous sample reset to J.
REQ-013 FSM states SHALL be IDLE, SYNC, DATA, EOP, ERR; all transitions only on sampleEn.
REQ-014 IDLE: K -> SYNC with zeroCnt=1; J and SE0 SHALL stay IDLE; SE1 stays IDLE, no error.
REQ-015 SYNC: decoded 0 -> zeroCnt+1 (saturate at 7).
REQ-016 SYNC: decoded 1 with zeroCnt>=5 -> DATA, rxActive=1, bitCnt=0, onesCnt=1.
REQ-017 SYNC: decoded 1 with zeroCnt<5 -> IDLE, no pulse; SE0/SE1 -> IDLE.
REQ-018 DATA: decoded bit after onesCnt==6 SHALL be a stuffed bit: 0 -> discarded, onesCnt=0; 1 -> ERR with rxError pulse.
REQ-019 DATA: non-stuffed bit SHALL shift into byte register MSB-side (LSB-first order), bitCnt+1, onesCnt = bit ? onesCnt+1 : 0.
REQ-020 On 8th bit: rxData updated, rxValid high exactly one useClk cycle following that sampleEn cycle, bitCnt wraps to 0.
REQ-021 DATA: SE0 -> EOP with se0Cnt=1; SE1 -> ERR with rxError pulse.
REQ-022 EOP: SE0 increments se0Cnt (saturate 3); J with se0Cnt>=2 -> IDLE, rxEop pulse, rxActive=0.
REQ-023 EOP: J with se0Cnt<2, K, or SE1 -> ERR with rxError pulse.
REQ-024 Valid EOP with bitCnt!=0 SHALL pulse rxError and rxEop in the same cycle; partial byte dropped.
REQ-025 ERR: rxActive=0; SHALL wait for SE0 followed by J, then IDLE; no further rxValid.
REQ-026 rxValid, rxEop, rxError SHALL never assert while sampleEn low for two consecutive cycles; counters hold when sampleEn low.
REQ-027 Previous-J/K register SHALL update only on J/K samples; after EOP it SHALL equal J.

Reset
REQ-028 rstN low SHALL asynchronously force: state=IDLE, rxData=0x00, rxValid=0, rxActive=0, rxEop=0, rxError=0, all counters 0, previous sample=J.
REQ-029 Reset deassertion mid-packet SHALL resume in IDLE; remaining packet bits are ignored until a new SYNC.

Structure
REQ-030 Shared package usb_rx_pkg SHALL hold: FSM state enum, line-state encodings, STUFF_LIMIT=6, EOP_SE0_MIN=2, SYNC_ZERO_MIN=5.
REQ-031 Sub-module nrzi_line_decoder SHALL do line classification plus NRZI decode (previous-sample register), outputting lineState and decoded bit.

Verification
REQ-032 Test: idle J, then KJKJKJKK, data byte 0xD2, SE0, SE0, J -> one rxValid with rxData=0xD2, then rxEop pulse, rxError never.
REQ-033 Test: SYNC, byte 0xFF with stuffed 0 after six 1s, byte 0x01, EOP -> rxData 0xFF then 0x01, no rxError.
REQ-034 Test: SYNC then seven consecutive decoded 1s -> rxError pulse on 7th, no rxValid, rxActive=0 until SE0+J.
REQ-035 Test: SYNC, 3 data bits, SE0, SE0, J -> rxEop and rxError same cycle, no rxValid.
REQ-036 Test: sampleEn toggled every 4th cycle during 0xD2 packet -> identical results to REQ-032; rstN pulsed low mid-byte -> all outputs 0 immediately, next full packet decodes correctly.
